// File: rtl/accumulate_arb_pkg.sv
// Shared types and helpers for the streaming accumulator and its arbiter.
// Result-width derivation, FSM encoding and operand sign/zero extension.
package accumulate_arb_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam int EXT_W = 64;

  function automatic int grow_w(input int count);
    return $clog2(count);
  endfunction

  function automatic int res_w(input int width, input int count);
    return width + $clog2(count);
  endfunction

  // Bits above 'width' are filled with the operand MSB when sgn is set, else zero.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] v, input int width,
                                           input bit sgn);
    logic [EXT_W-1:0] r;
    r = '0;
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < width) ? v[i] : (sgn & v[width-1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/accumulate_arb_arb_rr.sv
// One-hot arbiter: fixed priority (lowest index) or round-robin from pointer+1.
// Pointer moves to the granted index only when the grant is accepted (ack).
module arb_rr #(
  parameter int DEPTH = 2,
  parameter int RR    = 0,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] req,
  input  logic             en,
  input  logic             ack,
  output logic [DEPTH-1:0] gnt,
  output logic [PW-1:0]    gnt_idx
);

  logic [PW-1:0] ptr;
  logic          found;
  int            cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cand = (RR != 0) ? (int'(ptr) + 1 + i) % DEPTH : i;
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = PW'(cand);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(DEPTH - 1);
    end else if ((RR != 0) && ack) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/accumulate_arb.sv
// Multi-channel accumulator: arbitrates DEPTH operand streams, sums COUNT operands
// (or fewer on flush) and holds each widened result until res_rdy.
module accumulate_arb
  import accumulate_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 2,
  parameter int COUNT  = 4,
  parameter int SIGNED = 1,
  parameter int RR     = 0,
  localparam int GROW  = grow_w(COUNT),
  localparam int RW    = res_w(WIDTH, COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH-1:0]       arg_stb,
  input  logic [DEPTH*WIDTH-1:0] arg_dat,
  output logic [DEPTH-1:0]       arg_rdy,
  input  logic                   flush,
  output logic                   res_stb,
  output logic [RW-1:0]          res_dat,
  output logic [GROW:0]          res_cnt,
  input  logic                   res_rdy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = GROW + 1;

  state_t           state, state_nxt;
  logic [RW-1:0]    acc, sum, opnd;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [DEPTH-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             hs, close;

  arb_rr #(
    .DEPTH (DEPTH),
    .RR    (RR)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arg_stb),
    .en      (state == ST_ACC),
    .ack     (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign arg_rdy = gnt;
  assign hs      = |(arg_stb & gnt);
  assign opnd    = RW'(ext(EXT_W'(arg_dat[gnt_idx*WIDTH +: WIDTH]), WIDTH, SIGNED != 0));
  assign sum     = acc + (hs ? opnd : '0);
  assign cnt_nxt = cnt + CW'(hs);
  // A flush closes the group if anything is in it, counting a same-cycle accept.
  assign close   = (state == ST_ACC) &&
                   ((hs && (cnt_nxt == CW'(COUNT))) || (flush && (cnt_nxt != '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (close) state_nxt = ST_OUT;
      ST_OUT:  if (res_rdy) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      res_stb <= 1'b0;
      res_dat <= '0;
      res_cnt <= '0;
    end else if (close) begin
      res_dat <= sum;
      res_cnt <= cnt_nxt;
      res_stb <= 1'b1;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      if (hs) begin
        acc <= sum;
        cnt <= cnt_nxt;
      end
      if ((state == ST_OUT) && res_rdy) begin
        res_stb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accumulate_arb.sv
// Two accumulators on shared stimulus: unsigned/fixed-priority and signed/round-robin,
// each compared against an integer reference model.
module tb_accumulate_arb;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int C  = 4;
  localparam int RW = 10;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [D-1:0]   arg_stb;
  logic [D*W-1:0] arg_dat;
  logic           flush;
  logic           res_rdy;
  logic [D-1:0]   rdy_o[2];
  logic           stb_o[2];
  logic [RW-1:0]  dat_o[2];
  logic [CW-1:0]  cnt_o[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accumulate_arb #(.WIDTH(W), .DEPTH(D), .COUNT(C), .SIGNED(0), .RR(0)) dut_a (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(rdy_o[0]),
    .flush(flush), .res_stb(stb_o[0]), .res_dat(dat_o[0]), .res_cnt(cnt_o[0]),
    .res_rdy(res_rdy));

  accumulate_arb #(.WIDTH(W), .DEPTH(D), .COUNT(C), .SIGNED(1), .RR(1)) dut_b (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(rdy_o[1]),
    .flush(flush), .res_stb(stb_o[1]), .res_dat(dat_o[1]), .res_cnt(cnt_o[1]),
    .res_rdy(res_rdy));

  // Reference model; index 0 = unsigned fixed priority, 1 = signed round-robin.
  bit m_out[2];
  bit m_stb[2];
  int m_acc[2], m_cnt[2], m_ptr[2], m_res[2], m_rcnt[2];

  function automatic int m_grant(input int m);
    int ch;
    if (m_out[m]) return -1;
    for (int i = 0; i < D; i++) begin
      ch = (m == 1) ? (m_ptr[m] + 1 + i) % D : i;
      if (arg_stb[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [D-1:0] m_rdy(input int m);
    logic [D-1:0] r;
    int g;
    r = '0;
    g = m_grant(m);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int m_val(input int m, input int ch);
    logic [W-1:0] b;
    b = arg_dat[ch*W +: W];
    return (m == 1) ? int'($signed(b)) : int'(b);
  endfunction

  task automatic cycle();
    int g, a, c;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_out[m] = 0; m_stb[m] = 0; m_acc[m] = 0; m_cnt[m] = 0;
        m_ptr[m] = D - 1; m_res[m] = 0; m_rcnt[m] = 0;
      end else if (m_out[m]) begin
        if (res_rdy) begin m_out[m] = 0; m_stb[m] = 0; end
      end else begin
        g = m_grant(m); a = m_acc[m]; c = m_cnt[m];
        if (g >= 0) begin a += m_val(m, g); c++; m_ptr[m] = g; end
        if (c == C || (flush && c > 0)) begin
          m_res[m] = a; m_rcnt[m] = c; m_stb[m] = 1; m_out[m] = 1; m_acc[m] = 0; m_cnt[m] = 0;
        end else begin
          m_acc[m] = a; m_cnt[m] = c;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    arg_stb = 2'b01;
    arg_dat[W-1:0] = v;
    #1;
    cycle();
  endtask

  task automatic idle();
    arg_stb = '0; flush = 1'b0; res_rdy = 1'b1;
    #1;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; arg_stb = 2'b11; arg_dat = 16'h5a3c;
    #1; cycle(); #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (stb_o[m] !== 1'b0) begin errors++; $display("FAIL reset_stb[%0d] got %b exp 0", m, stb_o[m]); end
      checks++; if (dat_o[m] !== '0) begin errors++; $display("FAIL reset_dat[%0d] got %h exp 0", m, dat_o[m]); end
      checks++; if (cnt_o[m] !== '0) begin errors++; $display("FAIL reset_cnt[%0d] got %0d exp 0", m, cnt_o[m]); end
      checks++; if (rdy_o[m] !== 2'b01) begin errors++; $display("FAIL reset_rdy[%0d] got %b exp 01", m, rdy_o[m]); end
    end
    rst = 1'b0; arg_stb = '0;
  endtask

  task automatic test_basic();
    logic [W-1:0] vals[4];
    vals = '{8'd10, 8'd20, 8'd30, 8'd40};
    arg_stb = 2'b01; res_rdy = 1'b1; arg_dat = '0;
    for (int k = 0; k < 4; k++) begin
      arg_dat[W-1:0] = vals[k];
      #1;
      checks++; if (rdy_o[0] !== 2'b01) begin errors++; $display("FAIL basic_rdy k=%0d got %b exp 01", k, rdy_o[0]); end
      checks++; if (stb_o[0] !== 1'b0) begin errors++; $display("FAIL basic_early_stb k=%0d got %b exp 0", k, stb_o[0]); end
      cycle();
    end
    #1;
    checks++; if (stb_o[0] !== 1'b1) begin errors++; $display("FAIL basic_stb got %b exp 1", stb_o[0]); end
    checks++; if (dat_o[0] !== 10'd100) begin errors++; $display("FAIL basic_dat got %0d exp 100", dat_o[0]); end
    checks++; if (cnt_o[0] !== 3'd4) begin errors++; $display("FAIL basic_cnt got %0d exp 4", cnt_o[0]); end
    checks++; if (rdy_o[0] !== 2'b00) begin errors++; $display("FAIL basic_rdy_out got %b exp 00", rdy_o[0]); end
    checks++; if (dat_o[1] !== 10'd100) begin errors++; $display("FAIL basic_dat_b got %0d exp 100", dat_o[1]); end
    idle();
  endtask

  task automatic test_signed();
    for (int k = 0; k < 4; k++) push(8'h80);
    #1;
    checks++; if (dat_o[1] !== 10'h200) begin errors++; $display("FAIL signed_min got %h exp 200", dat_o[1]); end
    checks++; if (dat_o[0] !== 10'd512) begin errors++; $display("FAIL unsigned_128 got %0d exp 512", dat_o[0]); end
    idle();
    for (int k = 0; k < 4; k++) push(8'hff);
    #1;
    checks++; if (dat_o[0] !== 10'd1020) begin errors++; $display("FAIL unsigned_max got %0d exp 1020", dat_o[0]); end
    checks++; if (dat_o[1] !== 10'h3fc) begin errors++; $display("FAIL signed_m1 got %h exp 3fc", dat_o[1]); end
    idle();
    push(8'h80); push(8'h01); push(8'h01); push(8'h01);
    #1;
    checks++; if (dat_o[0] !== 10'd131) begin errors++; $display("FAIL unsigned_mix got %0d exp 131", dat_o[0]); end
    checks++; if (dat_o[1] !== 10'h383) begin errors++; $display("FAIL signed_mix got %h exp 383", dat_o[1]); end
    idle();
  endtask

  task automatic test_rr();
    rst = 1'b1; arg_stb = '0; #1; cycle(); rst = 1'b0;
    arg_stb = 2'b11; arg_dat = {8'd2, 8'd1}; res_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (rdy_o[0] !== 2'b01) begin errors++; $display("FAIL fixed_gnt k=%0d got %b exp 01", k, rdy_o[0]); end
      checks++; if (rdy_o[1] !== ((k % 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_gnt k=%0d got %b exp %b", k, rdy_o[1], (k % 2) ? 2'b10 : 2'b01);
      end
      cycle();
    end
    #1;
    checks++; if (dat_o[0] !== 10'd4) begin errors++; $display("FAIL fixed_sum got %0d exp 4", dat_o[0]); end
    checks++; if (dat_o[1] !== 10'd6) begin errors++; $display("FAIL rr_sum got %0d exp 6", dat_o[1]); end
    idle();
  endtask

  task automatic test_flush();
    push(8'd5); push(8'd7);
    arg_stb = '0; flush = 1'b1; #1; cycle(); flush = 1'b0; #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (stb_o[m] !== 1'b1) begin errors++; $display("FAIL flush_stb[%0d] got %b exp 1", m, stb_o[m]); end
      checks++; if (dat_o[m] !== 10'd12) begin errors++; $display("FAIL flush_dat[%0d] got %0d exp 12", m, dat_o[m]); end
      checks++; if (cnt_o[m] !== 3'd2) begin errors++; $display("FAIL flush_cnt[%0d] got %0d exp 2", m, cnt_o[m]); end
    end
    idle();
    flush = 1'b1; #1; cycle(); flush = 1'b0; #1;
    checks++; if (stb_o[0] !== 1'b0) begin errors++; $display("FAIL flush_empty got %b exp 0", stb_o[0]); end
    for (int k = 0; k < 4; k++) push(8'd1);
    #1;
    checks++; if (dat_o[0] !== 10'd4) begin errors++; $display("FAIL flush_next_dat got %0d exp 4", dat_o[0]); end
    checks++; if (cnt_o[0] !== 3'd4) begin errors++; $display("FAIL flush_next_cnt got %0d exp 4", cnt_o[0]); end
    idle();
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) push(8'd3);
    res_rdy = 1'b0;
    push(8'd3);
    arg_stb = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (stb_o[0] !== 1'b1) begin errors++; $display("FAIL stall_stb k=%0d got %b exp 1", k, stb_o[0]); end
      checks++; if (dat_o[0] !== 10'd12) begin errors++; $display("FAIL stall_dat k=%0d got %0d exp 12", k, dat_o[0]); end
      checks++; if (rdy_o[0] !== 2'b00 || rdy_o[1] !== 2'b00) begin
        errors++; $display("FAIL stall_rdy k=%0d got %b/%b exp 00/00", k, rdy_o[0], rdy_o[1]);
      end
      cycle();
    end
    res_rdy = 1'b1; #1;
    checks++; if (rdy_o[0] !== 2'b00) begin errors++; $display("FAIL stall_hs_rdy got %b exp 00", rdy_o[0]); end
    cycle(); #1;
    checks++; if (stb_o[0] !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", stb_o[0]); end
    checks++; if (rdy_o[0] !== 2'b01) begin errors++; $display("FAIL stall_resume got %b exp 01", rdy_o[0]); end
    checks++; if (rdy_o[1] !== m_rdy(1)) begin errors++; $display("FAIL stall_resume_b got %b exp %b", rdy_o[1], m_rdy(1)); end
    idle();
  endtask

  task automatic test_reset_mid();
    push(8'd50); push(8'd60);
    rst = 1'b1; arg_stb = '0; #1; cycle(); rst = 1'b0; #1;
    checks++; if (stb_o[0] !== 1'b0) begin errors++; $display("FAIL rstmid_stb got %b exp 0", stb_o[0]); end
    push(8'd1); push(8'd2); push(8'd3); push(8'd4);
    #1;
    checks++; if (dat_o[0] !== 10'd10) begin errors++; $display("FAIL rstmid_dat got %0d exp 10", dat_o[0]); end
    checks++; if (cnt_o[0] !== 3'd4) begin errors++; $display("FAIL rstmid_cnt got %0d exp 4", cnt_o[0]); end
    checks++; if (dat_o[1] !== 10'd10) begin errors++; $display("FAIL rstmid_dat_b got %0d exp 10", dat_o[1]); end
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      arg_stb = D'($urandom_range(0, 3));
      arg_dat = 16'($urandom);
      flush   = ($urandom_range(0, 7) == 0);
      res_rdy = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (rdy_o[m] !== m_rdy(m)) begin errors++; $display("FAIL rnd_rdy[%0d] k=%0d got %b exp %b", m, k, rdy_o[m], m_rdy(m)); end
        checks++; if (stb_o[m] !== m_stb[m]) begin errors++; $display("FAIL rnd_stb[%0d] k=%0d got %b exp %b", m, k, stb_o[m], m_stb[m]); end
        checks++; if (dat_o[m] !== RW'(m_res[m])) begin errors++; $display("FAIL rnd_dat[%0d] k=%0d got %h exp %h", m, k, dat_o[m], RW'(m_res[m])); end
        checks++; if (cnt_o[m] !== CW'(m_rcnt[m])) begin errors++; $display("FAIL rnd_cnt[%0d] k=%0d got %0d exp %0d", m, k, cnt_o[m], m_rcnt[m]); end
      end
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arg_stb = '0; arg_dat = '0; flush = 1'b0; res_rdy = 1'b1;
    #1; cycle(); cycle();
    test_reset();
    test_basic();
    test_signed();
    test_rr();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
